mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_mem_pkg.sv | 10 +
 rtl/mem_lane_align.sv | 28 ++
 rtl/mem_arbiter.sv | 81 ++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: arbiter FSM state encoding and data-access size codes.
package riscv_mem_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RD_IF = 2'd1;
  localparam state_t S_RD_DM = 2'd2;
  localparam logic [1:0] WHB_WORD = 2'b00;
  localparam logic [1:0] WHB_HALF = 2'b01;
  localparam logic [1:0] WHB_BYTE = 2'b10;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication, load extraction and misalignment check.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  whb,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_whb,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] rep_wdata,
  output logic [31:0] rd_data,
  output logic        misaligned
);
  logic [31:0] shifted;
  always_comb begin
    misaligned = (whb == 2'b11) || (whb == WHB_WORD && addr_lo != 2'b00) ||
                 (whb == WHB_HALF && addr_lo[0]);
    be = (whb == WHB_WORD) ? 4'b1111 :
         (whb == WHB_HALF) ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_lo;
    rep_wdata = (whb == WHB_WORD) ? wdata :
                (whb == WHB_HALF) ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    shifted = rdata >> {rd_off, 3'b000};
    rd_data = (rd_whb == WHB_WORD) ? rdata :
              (rd_whb == WHB_HALF) ? {16'h0, shifted[15:0]} : {24'h0, shifted[7:0]};
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and load/store ports.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_whb,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  state_t state;
  logic [CW-1:0] starve_cnt;
  logic [1:0] rd_whb, rd_off;
  logic idle, dm_sel, dm_go, if_go, dm_ok, rd_dm, mis;
  logic [3:0] be;
  logic [31:0] rep_wdata, rd_data;
  mem_lane_align u_align (
    .whb(dm_whb), .addr_lo(dm_addr[1:0]), .wdata(dm_wdata),
    .rd_whb(rd_whb), .rd_off(rd_off), .rdata(mem_rdata),
    .be(be), .rep_wdata(rep_wdata), .rd_data(rd_data), .misaligned(mis)
  );
  // Gating with rst keeps a reset cycle from issuing grants or delivering stale read data.
  always_comb begin
    idle = state == S_IDLE && !rst;
    dm_sel = dm_req && !(if_req && starve_cnt == CW'(STARVE_LIMIT));
    dm_go = idle && dm_sel;
    if_go = idle && if_req && !dm_sel;
    dm_ok = dm_go && !mis;
    rd_dm = dm_ok && !dm_we;
    if_gnt = if_go;
    dm_gnt = dm_go;
    dm_err = dm_go && mis;
    mem_en = if_go || dm_ok;
    mem_we = dm_ok && dm_we;
    mem_be = if_go ? 4'b1111 : dm_ok ? (dm_we ? be : 4'b1111) : 4'b0000;
    mem_addr = if_go ? (if_addr & ~32'h3) : dm_ok ? (dm_addr & ~32'h3) : 32'h0;
    mem_wdata = mem_we ? rep_wdata : 32'h0;
    if_rvalid = state == S_RD_IF && !rst;
    dm_rvalid = state == S_RD_DM && !rst;
    if_rdata = if_rvalid ? mem_rdata : 32'h0;
    dm_rdata = dm_rvalid ? rd_data : 32'h0;
    busy = state != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      starve_cnt <= '0;
      rd_whb <= 2'b00;
      rd_off <= 2'b00;
    end else begin
      state <= if_go ? S_RD_IF : rd_dm ? S_RD_DM : S_IDLE;
      if (if_go) starve_cnt <= '0;
      else if (dm_go && if_req && starve_cnt != CW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
      if (rd_dm) begin
        rd_whb <= dm_whb;
        rd_off <= dm_addr[1:0];
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table for single grants plus sequences for contention, starvation and reset.
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [1:0] dm_whb = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0, rword = 0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err, mem_en, mem_we, busy;
  logic [3:0] mem_be;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic is_if;
    logic [31:0] data;
    int cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic ir, dr, we;
    logic [1:0] whb;
    logic [31:0] addr, wdata, rword;
    logic eig, edg, eerr, een, ewe;
    logic [3:0] ebe;
    logic [31:0] emaddr, emwdata;
  } vec_t;
  vec_t v[13];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_whb(dm_whb), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Memory model: the word for the current stimulus appears one cycle after a read enable.
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= rword;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] whb,
                                           input logic [1:0] off);
    if (whb == 2'b00) return w;
    if (whb == 2'b01) return off[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
    case (off)
      2'd0: return {24'h0, w[7:0]};
      2'd1: return {24'h0, w[15:8]};
      2'd2: return {24'h0, w[23:16]};
      default: return {24'h0, w[31:24]};
    endcase
  endfunction

  task automatic push(input logic is_if, input logic [31:0] data);
    sb_t e;
    e.is_if = is_if;
    e.data = data;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (if_rvalid || dm_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid: got if=%0b dm=%0b expected none", if_rvalid, dm_rvalid);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("rvalid port", {if_rvalid, dm_rvalid}, e.is_if ? 32'd2 : 32'd1);
        chk("rdata", e.is_if ? if_rdata : dm_rdata, e.data);
        chk("read latency", 32'(cyc - e.cyc), 32'd1);
      end
    end
  end

  initial begin
    v[0]  = '{1,0,0,2'd0,32'h10,0,32'hCAFEBABE, 1,0,0,1,0,4'hF,32'h10,0};
    v[1]  = '{0,1,1,2'd2,32'h203,32'hAB,0, 0,1,0,1,1,4'h8,32'h200,32'hABABABAB};
    v[2]  = '{0,1,1,2'd1,32'h102,32'hBEEF,0, 0,1,0,1,1,4'hC,32'h100,32'hBEEFBEEF};
    v[3]  = '{0,1,1,2'd1,32'h100,32'hFFFF1357,0, 0,1,0,1,1,4'h3,32'h100,32'h13571357};
    v[4]  = '{0,1,1,2'd0,32'h108,32'h11223344,0, 0,1,0,1,1,4'hF,32'h108,32'h11223344};
    v[5]  = '{0,1,0,2'd1,32'h102,0,32'h12345678, 0,1,0,1,0,4'hF,32'h100,0};
    v[6]  = '{0,1,0,2'd2,32'h101,0,32'h12345678, 0,1,0,1,0,4'hF,32'h100,0};
    v[7]  = '{0,1,0,2'd2,32'h103,0,32'h12345678, 0,1,0,1,0,4'hF,32'h100,0};
    v[8]  = '{0,1,0,2'd0,32'h104,0,32'hDEADBEEF, 0,1,0,1,0,4'hF,32'h104,0};
    v[9]  = '{0,1,1,2'd0,32'h101,32'h99,0, 0,1,1,0,0,4'h0,0,0};
    v[10] = '{0,1,0,2'd1,32'h103,0,0, 0,1,1,0,0,4'h0,0,0};
    v[11] = '{0,1,0,2'd3,32'h100,0,0, 0,1,1,0,0,4'h0,0,0};
    v[12] = '{1,0,0,2'd0,32'h20000004,0,32'h00C0FFEE, 1,0,0,1,0,4'hF,32'h20000004,0};

    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("reset ctrl", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err, mem_en, mem_we, busy}, 0);
    chk("reset data", mem_addr | mem_wdata | if_rdata | dm_rdata | {28'h0, mem_be}, 0);

    for (int i = 0; i < 13; i++) begin
      tick();
      if_req = v[i].ir;
      dm_req = v[i].dr;
      dm_we = v[i].we;
      dm_whb = v[i].whb;
      if_addr = v[i].addr;
      dm_addr = v[i].addr;
      dm_wdata = v[i].wdata;
      rword = v[i].rword;
      @(negedge clk);
      chk($sformatf("v%0d gnt/err", i), {if_gnt, dm_gnt, dm_err}, {v[i].eig, v[i].edg, v[i].eerr});
      chk($sformatf("v%0d en/we/be", i), {mem_en, mem_we, mem_be}, {v[i].een, v[i].ewe, v[i].ebe});
      chk($sformatf("v%0d mem_addr", i), mem_addr, v[i].emaddr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, v[i].emwdata);
      if (v[i].een && !v[i].ewe)
        push(v[i].ir, v[i].ir ? v[i].rword : exp_load(v[i].rword, v[i].whb, v[i].addr[1:0]));
      tick();
      if_req = 0;
      dm_req = 0;
      @(negedge clk);
      chk($sformatf("v%0d busy", i), {31'h0, busy}, {31'h0, v[i].een && !v[i].ewe});
      tick();
    end

    tick();
    if_req = 1;
    if_addr = 32'h40;
    dm_req = 1;
    dm_we = 0;
    dm_whb = 2'b00;
    dm_addr = 32'h100;
    rword = 32'h0BADF00D;
    @(negedge clk);
    chk("contend gnt", {if_gnt, dm_gnt}, 2'b01);
    push(0, 32'h0BADF00D);
    tick();
    dm_req = 0;
    @(negedge clk);
    chk("starve after dm", 32'(dut.starve_cnt), 1);
    chk("no gnt in RD_DM", {if_gnt, dm_gnt}, 0);
    tick();
    rword = 32'h40404040;
    @(negedge clk);
    chk("if after dm", {if_gnt, mem_addr}, {1'b1, 32'h40});
    push(1, 32'h40404040);
    tick();
    if_req = 0;
    @(negedge clk);
    chk("starve cleared", 32'(dut.starve_cnt), 0);
    tick();

    tick();
    if_req = 1;
    if_addr = 32'h80;
    dm_req = 1;
    dm_we = 1;
    dm_whb = 2'b00;
    dm_addr = 32'h300;
    dm_wdata = 32'h77;
    rword = 32'h80808080;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        chk("starve saturated", 32'(dut.starve_cnt), 4);
        push(1, 32'h80808080);
      end
      chk($sformatf("starve k%0d gnt", k), {if_gnt, dm_gnt}, k == 4 ? 2'b10 : 2'b01);
      tick();
    end
    if_req = 0;
    dm_req = 0;
    tick();
    tick();

    dm_req = 1;
    dm_we = 0;
    dm_whb = 2'b00;
    dm_addr = 32'h104;
    rword = 32'h55AA55AA;
    @(negedge clk);
    chk("pre-reset gnt", {31'h0, dm_gnt}, 1);
    tick();
    dm_req = 0;
    rst = 1;
    if_req = 1;
    if_addr = 32'hC0;
    @(negedge clk);
    chk("reset drops rvalid", {dm_rvalid, if_gnt}, 0);
    tick();
    rst = 0;
    rword = 32'h0C0C0C0C;
    @(negedge clk);
    chk("busy after reset", {dm_rvalid, busy}, 0);
    chk("rearbitrate", {if_gnt, mem_addr}, {1'b1, 32'hC0});
    push(1, 32'h0C0C0C0C);
    tick();
    if_req = 0;
    tick();
    tick();
    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
